// File: rtl/alu_pkg.sv
// Shared opcode definitions and helpers for the registered ALU and its iterative engine.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_ASHL = 4'd1,
        OP_XNOR = 4'd2,
        OP_DIV2 = 4'd3,
        OP_LOAD = 4'd4,
        OP_PASS = 4'd5,
        OP_NEG  = 4'd6,
        OP_SHLN = 4'd7,
        OP_SHRN = 4'd8,
        OP_MUL  = 4'd9
    } op_t;

    localparam logic [3:0] OP_LAST_LEGAL = 4'd9;

    function automatic logic is_multicycle(op_t op);
        return (op == OP_SHLN) || (op == OP_SHRN) || (op == OP_MUL);
    endfunction

endpackage

// File: rtl/alu_iter.sv
// Iterative engine for SHLN/SHRN/MUL: one shift or shift-add step per clock,
// with fin flagging the cycle whose step is the last one.
module alu_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             go,
    input  op_t              op,
    input  logic [WIDTH-1:0] ac,
    input  logic [WIDTH-1:0] dr,
    input  logic [SHW-1:0]   shamt,
    output logic             fin,
    output logic [WIDTH-1:0] res,
    output logic             e_out
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0]      cnt_q, cnt_d;
    op_t                op_q, op_d;
    logic [WIDTH-1:0]   sh_q, sh_d;
    logic [2*WIDTH-1:0] mc_q, mc_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;

    logic [WIDTH-1:0]   sh_step;
    logic               e_step;
    logic [2*WIDTH-1:0] mc_step;
    logic [2*WIDTH-1:0] acc_step;

    // One iteration; for MUL, sh_q holds the remaining multiplier bits.
    always_comb begin
        sh_step  = sh_q;
        e_step   = 1'b0;
        mc_step  = mc_q;
        acc_step = acc_q;
        case (op_q)
            OP_SHLN: begin
                sh_step = {sh_q[WIDTH-2:0], 1'b0};
                e_step  = sh_q[WIDTH-1];
            end
            OP_SHRN: begin
                sh_step = {sh_q[WIDTH-1], sh_q[WIDTH-1:1]};
                e_step  = sh_q[0];
            end
            default: begin
                sh_step  = {1'b0, sh_q[WIDTH-1:1]};
                mc_step  = {mc_q[2*WIDTH-2:0], 1'b0};
                acc_step = acc_q + (sh_q[0] ? mc_q : '0);
            end
        endcase
    end

    always_comb begin
        res   = sh_step;
        e_out = e_step;
        if (op_q == OP_MUL) begin
            res   = acc_step[WIDTH-1:0];
            e_out = |acc_step[2*WIDTH-1:WIDTH];
        end
    end

    assign fin = (cnt_q == CW'(1));

    always_comb begin
        cnt_d = cnt_q;
        op_d  = op_q;
        sh_d  = sh_q;
        mc_d  = mc_q;
        acc_d = acc_q;
        if (go) begin
            op_d  = op;
            sh_d  = dr;
            mc_d  = {{WIDTH{1'b0}}, ac};
            acc_d = '0;
            cnt_d = (op == OP_MUL) ? CW'(WIDTH) : CW'(shamt);
        end else if (cnt_q != '0) begin
            sh_d  = sh_step;
            mc_d  = mc_step;
            acc_d = acc_step;
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            op_q  <= OP_ADD;
        end else begin
            cnt_q <= cnt_d;
            op_q  <= op_d;
        end
    end

    always_ff @(posedge clk) begin
        sh_q  <= sh_d;
        mc_q  <= mc_d;
        acc_q <= acc_d;
    end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU: single-cycle datapath, IDLE/RUN control FSM and output
// registers, delegating multi-cycle shifts and multiply to alu_iter.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] ac,
    input  logic [WIDTH-1:0] dr,
    input  logic [SHW-1:0]   shamt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             e,
    output logic             z
);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t           state_q, state_d;
    op_t              op_in;
    logic             accept, multi, go, fin;
    logic [WIDTH-1:0] it_res;
    logic             it_e;
    logic [WIDTH-1:0] sc_res;
    logic             sc_e, sc_upd;

    logic [WIDTH-1:0] result_q, result_d;
    logic             e_q, e_d, z_q, z_d, done_q, done_d;

    assign op_in  = op_t'(op);
    assign accept = start && (state_q == S_IDLE);
    // A zero-length shift degenerates to a single-cycle LOAD that keeps e.
    assign multi  = is_multicycle(op_in) && ((op_in == OP_MUL) || (shamt != '0));
    assign go     = accept && multi;

    alu_iter #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_iter (
        .clk   (clk),
        .rst_n (rst_n),
        .go    (go),
        .op    (op_in),
        .ac    (ac),
        .dr    (dr),
        .shamt (shamt),
        .fin   (fin),
        .res   (it_res),
        .e_out (it_e)
    );

    always_comb begin
        sc_res = result_q;
        sc_e   = e_q;
        sc_upd = 1'b1;
        case (op_in)
            OP_ADD:  {sc_e, sc_res} = {1'b0, ac} + {1'b0, dr};
            OP_ASHL: begin
                sc_res = {dr[WIDTH-2:0], 1'b0};
                sc_e   = dr[WIDTH-1];
            end
            OP_XNOR: sc_res = ~(ac ^ dr);
            OP_DIV2: begin
                sc_res = {dr[WIDTH-1], dr[WIDTH-1:1]};
                sc_e   = dr[0];
            end
            OP_LOAD: sc_res = dr;
            OP_PASS: sc_res = ac;
            OP_NEG:  sc_res = -dr;
            OP_SHLN, OP_SHRN: sc_res = dr;
            default: sc_upd = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (go)  state_d = S_RUN;
            S_RUN:   if (fin) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        result_d = result_q;
        e_d      = e_q;
        done_d   = 1'b0;
        if (state_q == S_RUN) begin
            if (fin) begin
                result_d = it_res;
                e_d      = it_e;
                done_d   = 1'b1;
            end
        end else if (accept && !multi) begin
            done_d = 1'b1;
            if (sc_upd) begin
                result_d = sc_res;
                e_d      = sc_e;
            end
        end
        z_d = (result_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            e_q      <= 1'b0;
            z_q      <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            e_q      <= e_d;
            z_q      <= z_d;
            done_q   <= done_d;
        end
    end

    assign busy   = (state_q == S_RUN);
    assign done   = done_q;
    assign result = result_q;
    assign e      = e_q;
    assign z      = z_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq with hand-computed expectations.
module tb_alu_seq;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] op;
    logic [7:0] ac, dr;
    logic [2:0] shamt;
    logic       busy, done, e, z;
    logic [7:0] result;

    int n_chk  = 0;
    int n_fail = 0;
    int lat;
    logic stable;

    alu_seq #(.WIDTH(8), .SHW(3)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .ac     (ac),
        .dr     (dr),
        .shamt  (shamt),
        .busy   (busy),
        .done   (done),
        .result (result),
        .e      (e),
        .z      (z)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t limit 200000", $time);
        $fatal(1);
    end

    task automatic issue(input logic [3:0] o, input logic [7:0] a, input logic [7:0] d,
                         input logic [2:0] s);
        op = o; ac = a; dr = d; shamt = s; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int l, output logic st);
        logic [7:0] r0;
        logic e0, z0;
        r0 = result; e0 = e; z0 = z;
        l = -1; st = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (done) begin
                l = i;
                break;
            end
            if (result !== r0 || e !== e0 || z !== z0) st = 1'b0;
        end
    endtask

    task automatic test_reset();
        start = 1'b0; op = 4'h0; ac = 8'h00; dr = 8'h00; shamt = 3'd0;
        rst_n = 1'b0;
        #12;
        n_chk++;
        if ({busy, done, result, e, z} !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_hold: got busy=%b done=%b res=%h e=%b z=%b want 0 0 00 0 1",
                     busy, done, result, e, z);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        n_chk++;
        if ({busy, done, result, e, z} !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_release: got busy=%b done=%b res=%h e=%b z=%b want 0 0 00 0 1",
                     busy, done, result, e, z);
        end
    endtask

    task automatic test_add();
        issue(OP_ADD, 8'h31, 8'hC4, 3'd0);
        n_chk++;
        if ({busy, done, result, e, z} !== {1'b0, 1'b1, 8'hF5, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL add_nocarry: got busy=%b done=%b res=%h e=%b z=%b want 0 1 f5 0 0",
                     busy, done, result, e, z);
        end
        @(posedge clk); #1;
        n_chk++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL add_done_pulse: got done=%b want 0", done);
        end
        issue(OP_ADD, 8'hC1, 8'hA3, 3'd0);
        n_chk++;
        if ({done, result, e, z} !== {1'b1, 8'h64, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL add_carry: got done=%b res=%h e=%b z=%b want 1 64 1 0",
                     done, result, e, z);
        end
    endtask

    task automatic test_back_to_back();
        issue(OP_ASHL, 8'h00, 8'hB1, 3'd0);
        n_chk++;
        if ({done, result, e, z} !== {1'b1, 8'h62, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL ashl: got done=%b res=%h e=%b z=%b want 1 62 1 0", done, result, e, z);
        end
        issue(OP_DIV2, 8'h00, 8'hB1, 3'd0);
        n_chk++;
        if ({done, result, e, z} !== {1'b1, 8'hD8, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL div2: got done=%b res=%h e=%b z=%b want 1 d8 1 0", done, result, e, z);
        end
        issue(OP_XNOR, 8'hB2, 8'h86, 3'd0);
        n_chk++;
        if ({done, result, e, z} !== {1'b1, 8'hCB, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL xnor: got done=%b res=%h e=%b z=%b want 1 cb 1 0", done, result, e, z);
        end
        issue(OP_NEG, 8'h00, 8'h9A, 3'd0);
        n_chk++;
        if ({done, result, e, z} !== {1'b1, 8'h66, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL neg: got done=%b res=%h e=%b z=%b want 1 66 1 0", done, result, e, z);
        end
        issue(OP_LOAD, 8'h77, 8'h00, 3'd0);
        n_chk++;
        if ({done, result, e, z} !== {1'b1, 8'h00, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL load_zero: got done=%b res=%h e=%b z=%b want 1 00 1 1", done, result, e, z);
        end
        issue(OP_PASS, 8'h5A, 8'h00, 3'd0);
        n_chk++;
        if ({done, result, e, z} !== {1'b1, 8'h5A, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL pass: got done=%b res=%h e=%b z=%b want 1 5a 1 0", done, result, e, z);
        end
    endtask

    task automatic test_shifts();
        issue(OP_SHLN, 8'h00, 8'h81, 3'd3);
        n_chk++;
        if ({busy, done} !== 2'b10) begin
            n_fail++;
            $display("FAIL shln_busy: got busy=%b done=%b want 1 0", busy, done);
        end
        ac = 8'hFF; dr = 8'hFF; shamt = 3'd7;
        wait_done(lat, stable);
        n_chk++;
        if (lat != 3 || stable !== 1'b1 || {busy, result, e, z} !== {1'b0, 8'h08, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL shln3: got lat=%0d stable=%b busy=%b res=%h e=%b z=%b want 3 1 0 08 0 0",
                     lat, stable, busy, result, e, z);
        end
        issue(OP_SHRN, 8'h00, 8'h80, 3'd7);
        wait_done(lat, stable);
        n_chk++;
        if (lat != 7 || stable !== 1'b1 || {result, e, z} !== {8'hFF, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL shrn7: got lat=%0d stable=%b res=%h e=%b z=%b want 7 1 ff 0 0",
                     lat, stable, result, e, z);
        end
        issue(OP_SHRN, 8'h00, 8'h81, 3'd1);
        wait_done(lat, stable);
        n_chk++;
        if (lat != 1 || {result, e, z} !== {8'hC0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL shrn1: got lat=%0d res=%h e=%b z=%b want 1 c0 1 0", lat, result, e, z);
        end
        issue(OP_SHLN, 8'h00, 8'h3C, 3'd0);
        n_chk++;
        if ({busy, done, result, e, z} !== {1'b0, 1'b1, 8'h3C, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL shln0: got busy=%b done=%b res=%h e=%b z=%b want 0 1 3c 1 0",
                     busy, done, result, e, z);
        end
    endtask

    task automatic test_mul();
        issue(OP_MUL, 8'h0F, 8'h11, 3'd0);
        ac = 8'hAA; dr = 8'h55;
        wait_done(lat, stable);
        n_chk++;
        if (lat != 8 || stable !== 1'b1 || {result, e, z} !== {8'hFF, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL mul_0f_11: got lat=%0d stable=%b res=%h e=%b z=%b want 8 1 ff 0 0",
                     lat, stable, result, e, z);
        end
        issue(OP_MUL, 8'h10, 8'h10, 3'd0);
        wait_done(lat, stable);
        n_chk++;
        if (lat != 8 || {result, e, z} !== {8'h00, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL mul_10_10: got lat=%0d res=%h e=%b z=%b want 8 00 1 1", lat, result, e, z);
        end
    endtask

    task automatic test_ignore_busy();
        int ndone, first;
        issue(OP_MUL, 8'h03, 8'h05, 3'd0);
        op = OP_ADD; ac = 8'h01; dr = 8'h01; start = 1'b1;
        ndone = 0; first = -1;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            if (i == 2) start = 1'b0;
            if (done) begin
                ndone++;
                if (first < 0) first = i;
            end
        end
        n_chk++;
        if (ndone != 1 || first != 8 || {result, e, z} !== {8'h0F, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL ignore_busy: got dones=%0d first=%0d res=%h e=%b z=%b want 1 8 0f 0 0",
                     ndone, first, result, e, z);
        end
    endtask

    task automatic test_illegal();
        issue(4'hF, 8'h12, 8'h34, 3'd0);
        n_chk++;
        if ({busy, done, result, e, z} !== {1'b0, 1'b1, 8'h0F, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL illegal_f: got busy=%b done=%b res=%h e=%b z=%b want 0 1 0f 0 0",
                     busy, done, result, e, z);
        end
        issue(4'hA, 8'hFF, 8'hFF, 3'd5);
        n_chk++;
        if ({busy, done, result, e, z} !== {1'b0, 1'b1, 8'h0F, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL illegal_a: got busy=%b done=%b res=%h e=%b z=%b want 0 1 0f 0 0",
                     busy, done, result, e, z);
        end
    endtask

    task automatic test_reset_mid_op();
        int ndone;
        issue(OP_MUL, 8'h0F, 8'h11, 3'd0);
        for (int i = 0; i < 3; i++) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if ({busy, done, result, e, z} !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_mid: got busy=%b done=%b res=%h e=%b z=%b want 0 0 00 0 1",
                     busy, done, result, e, z);
        end
        @(posedge clk); @(negedge clk); rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (done || busy) ndone++;
        end
        n_chk++;
        if (ndone != 0 || result !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_no_done: got done/busy cycles=%0d res=%h want 0 00", ndone, result);
        end
        issue(OP_ADD, 8'h31, 8'hC4, 3'd0);
        n_chk++;
        if ({done, result, e, z} !== {1'b1, 8'hF5, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL after_reset_add: got done=%b res=%h e=%b z=%b want 1 f5 0 0",
                     done, result, e, z);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_shifts();
        test_mul();
        test_ignore_busy();
        test_illegal();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
